product_accumulator: RTL and testbench



---
 rtl/product_accumulator.sv | 76 +++++++
 tb/tb_product_accumulator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Sums a batch of COUNT unsigned products and presents the total on a
// valid/ready output. Input accepts are blocked while a finished batch waits.
module product_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12,
  parameter int COUNT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_overflow
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             last;
  logic [ACC_W:0]   sum_ext;

  assign in_ready     = (state == ACCUM);
  assign out_valid    = (state == HOLD);
  assign out_sum      = acc;
  assign out_overflow = ovf;

  // A product offered alongside clear is dropped even though in_ready is high.
  assign accept  = in_valid & in_ready & ~clear;
  assign last    = (count == LAST);
  assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_p};

  // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && last) state_nxt = HOLD;
      HOLD:    if (out_ready)      state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
    if (clear) state_nxt = ACCUM;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc   <= '0;
      ovf   <= 1'b0;
      count <= '0;
    end else if (accept) begin
      acc   <= sum_ext[ACC_W-1:0];
      ovf   <= ovf | sum_ext[ACC_W];
      count <= last ? '0 : count + CNT_W'(1);
    end else if (state == HOLD && out_ready) begin
      // Batch handed off: start the next one from zero.
      acc <= '0;
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a default instance and an ACC_W=9
// instance share one stimulus stream; per-instance scoreboards check each batch.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_p = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_overflow;
  logic [11:0] out_sum;
  logic        in_ready9, out_valid9, out_overflow9;
  logic [8:0]  out_sum9;

  int errors = 0;
  int checks = 0;

  logic [12:0] exp_q[$];
  logic [9:0]  exp9_q[$];

  always #5 clk = ~clk;

  product_accumulator dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_p(in_p), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_overflow(out_overflow)
  );

  product_accumulator #(.PROD_W(8), .ACC_W(9), .COUNT(4)) dut9 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready9),
    .in_p(in_p), .out_valid(out_valid9), .out_ready(out_ready), .out_sum(out_sum9),
    .out_overflow(out_overflow9)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [11:0] s, input logic o,
                          input logic [8:0] s9, input logic o9);
    exp_q.push_back({o, s});
    exp9_q.push_back({o9, s9});
  endtask

  task automatic send(input logic [7:0] p);
    int n = 0;
    in_valid = 1'b1;
    in_p     = p;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("send_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    send(a); send(b); send(c); send(d);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_batch", {19'd0, out_overflow, out_sum}, 32'h0);
      else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        check("batch_sum", 32'(out_sum), 32'(e[11:0]));
        check("batch_ovf", 32'(out_overflow), 32'(e[12]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid9 && out_ready) begin
      if (exp9_q.size() == 0) check("unexpected_batch9", {22'd0, out_overflow9, out_sum9}, 32'h0);
      else begin
        logic [9:0] e;
        e = exp9_q.pop_front();
        check("batch9_sum", 32'(out_sum9), 32'(e[8:0]));
        check("batch9_ovf", 32'(out_overflow9), 32'(e[9]));
      end
    end
  end

  initial begin
    int gap;
    step(2);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_ovf", 32'(out_overflow), 32'd0);
    check("rst_out_sum9", 32'(out_sum9), 32'd0);
    rst = 1'b0;
    step();

    // Back-to-back batch, consumer always ready.
    out_ready = 1'b1;
    push_exp(12'h02A, 1'b0, 9'h02A, 1'b0);
    send(8'h00); send(8'h07); send(8'h0E);
    check("b2b_not_early", 32'(out_valid), 32'd0);
    send(8'h15);
    check("b2b_valid_rise", 32'(out_valid), 32'd1);
    check("b2b_in_ready_low", 32'(in_ready), 32'd0);
    step();
    check("b2b_pulse_width", 32'(out_valid), 32'd0);
    check("b2b_in_ready_back", 32'(in_ready), 32'd1);

    // Same products with idle gaps between them.
    push_exp(12'h02A, 1'b0, 9'h02A, 1'b0);
    for (int i = 0; i < 4; i++) begin
      gap = $urandom_range(2, 3);
      step(gap);
      send(8'(7 * i));
      if (i == 2) check("gap_not_early", 32'(out_valid), 32'd0);
    end
    check("gap_valid_rise", 32'(out_valid), 32'd1);
    step();

    // Backpressure: HOLD ignores in_valid while the consumer stalls.
    out_ready = 1'b0;
    push_exp(12'h02A, 1'b0, 9'h02A, 1'b0);
    send4(8'h00, 8'h07, 8'h0E, 8'h15);
    in_valid = 1'b1;
    in_p     = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sum_stable", 32'(out_sum), 32'h02A);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    push_exp(12'h00A, 1'b0, 9'h00A, 1'b0);
    send4(8'h01, 8'h02, 8'h03, 8'h04);
    step();

    // Clear mid-batch, with a product offered in the same cycle.
    send(8'h07); send(8'h0E);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_p     = 8'h50;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_acc_zero", 32'(out_sum), 32'd0);
    check("clr_in_ready", 32'(in_ready), 32'd1);
    push_exp(12'h00A, 1'b0, 9'h00A, 1'b0);
    send4(8'h01, 8'h02, 8'h03, 8'h04);
    step();

    // Clear while holding a finished batch discards it.
    out_ready = 1'b0;
    send4(8'h10, 8'h10, 8'h10, 8'h10);
    check("clr_hold_valid", 32'(out_valid), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_hold_drop", 32'(out_valid), 32'd0);
    check("clr_hold_sum", 32'(out_sum), 32'd0);

    // Reset while holding a finished batch.
    send4(8'h00, 8'h07, 8'h0E, 8'h15);
    check("rst_hold_sum", 32'(out_sum), 32'h02A);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    check("rst_hold_ready", 32'(in_ready), 32'd1);
    check("rst_hold_sum0", 32'(out_sum), 32'd0);
    out_ready = 1'b1;
    push_exp(12'h040, 1'b0, 9'h040, 1'b0);
    send4(8'h10, 8'h10, 8'h10, 8'h10);
    step();

    // Overflow only in the narrow accumulator, then a clean batch after it.
    push_exp(12'h384, 1'b0, 9'h184, 1'b1);
    send4(8'hE1, 8'hE1, 8'hE1, 8'hE1);
    step();
    push_exp(12'h004, 1'b0, 9'h004, 1'b0);
    send4(8'h01, 8'h01, 8'h01, 8'h01);
    step(3);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("scoreboard9_drained", 32'(exp9_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
